// File: rtl/ssd1306_spi_sink.sv
// SPI-slave sink modelling the SSD1306 write path: deserializes bytes, decodes the
// command subset used by the firmware and emits framebuffer writes for data bytes.
module ssd1306_spi_sink #(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int FB_ADDR_LEN = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sck_i,
  input  logic                   mosi_i,
  input  logic                   cs_n_i,
  input  logic                   dc_i,
  output logic                   fb_we_o,
  output logic [FB_ADDR_LEN-1:0] fb_addr_o,
  output logic [7:0]             fb_wdata_o,
  output logic                   display_on_o,
  output logic                   invert_o,
  output logic [7:0]             contrast_o
);

  // state  | meaning
  // S_CMD  | waiting for an opcode
  // S_ARG1 | opcode held, waiting for first argument
  // S_ARG2 | 0x21/0x22 held with first argument, waiting for second
  typedef enum logic [1:0] {S_CMD, S_ARG1, S_ARG2} state_t;

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  localparam logic [1:0] MODE_H = 2'd0;
  localparam logic [1:0] MODE_V = 2'd1;
  localparam logic [1:0] MODE_P = 2'd2;

  logic [1:0] sck_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic       sck_d_q;
  logic       sck_rise;

  logic [2:0] bitcnt_q;
  logic [6:0] sr_q;
  logic [7:0] byte_q;
  logic       bdc_q;
  logic       byte_vld_q;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [CW-1:0] arg1_q, arg1_d;
  logic [1:0] mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic       disp_q, disp_d, inv_q, inv_d;
  logic [7:0] contrast_q, contrast_d;
  logic       fb_we_q, fb_we_d;
  logic [FB_ADDR_LEN-1:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_wdata_q, fb_wdata_d;

  logic          col_at_end, page_at_end;
  logic [CW-1:0] col_next;
  logic [PW-1:0] page_next;

  // All four inputs share the same synchronizer depth so dc/mosi stay aligned with sck.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= '0;
      sck_d_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      dc_sync_q   <= {dc_sync_q[0], dc_i};
      sck_d_q     <= sck_sync_q[1];
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_d_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bitcnt_q   <= '0;
      sr_q       <= '0;
      byte_q     <= '0;
      bdc_q      <= 1'b0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (cs_sync_q[1]) begin
        bitcnt_q <= '0;
      end else if (sck_rise) begin
        sr_q     <= {sr_q[5:0], mosi_sync_q[1]};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_q     <= {sr_q, mosi_sync_q[1]};
          bdc_q      <= dc_sync_q[1];
          byte_vld_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_CMD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_vld_q) begin
      if (bdc_q) begin
        state_d = S_CMD;
      end else begin
        case (state_q)
          S_CMD:   if (byte_q inside {8'h20, 8'h81, 8'h21, 8'h22, 8'h8D, 8'hA8,
                                      8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB})
                     state_d = S_ARG1;
          S_ARG1:  state_d = (op_q == 8'h21 || op_q == 8'h22) ? S_ARG2 : S_CMD;
          default: state_d = S_CMD;
        endcase
      end
    end
  end

  // Pointers only ever compare equal against the end value, so start > end wraps by field width.
  assign col_at_end  = (col_q == col_end_q);
  assign page_at_end = (page_q == page_end_q);
  assign col_next    = col_at_end  ? col_start_q  : col_q + 1'b1;
  assign page_next   = page_at_end ? page_start_q : page_q + 1'b1;

  always_comb begin
    op_d         = op_q;
    arg1_d       = arg1_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    contrast_d   = contrast_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    if (byte_vld_q) begin
      if (bdc_q) begin
        fb_we_d    = 1'b1;
        fb_addr_d  = {page_q, col_q};
        fb_wdata_d = byte_q;
        case (mode_q)
          MODE_H: begin
            col_d = col_next;
            if (col_at_end) page_d = page_next;
          end
          MODE_V: begin
            page_d = page_next;
            if (page_at_end) col_d = col_next;
          end
          default: col_d = col_next;
        endcase
      end else begin
        case (state_q)
          S_CMD: begin
            op_d = byte_q;
            if (byte_q == 8'hAE) disp_d = 1'b0;
            if (byte_q == 8'hAF) disp_d = 1'b1;
            if (byte_q == 8'hA6) inv_d = 1'b0;
            if (byte_q == 8'hA7) inv_d = 1'b1;
            if (byte_q[7:3] == 5'b10110) page_d = byte_q[PW-1:0];
            if (byte_q[7:4] == 4'h0) col_d = {col_q[CW-1:4], byte_q[3:0]};
            if (byte_q[7:3] == 5'b00010) col_d = {byte_q[2:0], col_q[3:0]};
          end
          S_ARG1: begin
            case (op_q)
              8'h20:   mode_d = (byte_q[1:0] == 2'd3) ? MODE_P : byte_q[1:0];
              8'h81:   contrast_d = byte_q;
              default: arg1_d = byte_q[CW-1:0];
            endcase
          end
          default: begin
            if (op_q == 8'h21) begin
              col_start_d = arg1_q;
              col_end_d   = byte_q[CW-1:0];
              col_d       = arg1_q;
            end else if (op_q == 8'h22) begin
              page_start_d = arg1_q[PW-1:0];
              page_end_d   = byte_q[PW-1:0];
              page_d       = arg1_q[PW-1:0];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q         <= '0;
      arg1_q       <= '0;
      mode_q       <= MODE_P;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      contrast_q   <= 8'h7F;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
    end else begin
      op_q         <= op_d;
      arg1_q       <= arg1_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      contrast_q   <= contrast_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  assign fb_we_o      = fb_we_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_wdata_o   = fb_wdata_q;
  assign display_on_o = disp_q;
  assign invert_o     = inv_q;
  assign contrast_o   = contrast_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: directed scenarios plus a random byte stream checked
// against a byte-level model of the SSD1306 command/data rules.
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0, mosi = 1'b0, cs_n = 1'b1, dc = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       display_on, invert;
  logic [7:0] contrast;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ssd1306_spi_sink #(.COLS(128), .PAGES(8), .FB_ADDR_LEN(10)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck), .mosi_i(mosi), .cs_n_i(cs_n), .dc_i(dc),
    .fb_we_o(fb_we), .fb_addr_o(fb_addr), .fb_wdata_o(fb_wdata),
    .display_on_o(display_on), .invert_o(invert), .contrast_o(contrast)
  );

  // Model state: plain integers, pending-argument count instead of FSM states.
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_inv, m_con;
  int m_pend, m_op, m_a1;
  int exp_addr[$], exp_data[$], got_addr[$], got_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_disp = 0; m_inv = 0; m_con = 127; m_pend = 0; m_op = 0; m_a1 = 0;
    exp_addr.delete(); exp_data.delete();
  endfunction

  function automatic void model_byte(input int b, input bit is_data);
    if (is_data) begin
      exp_addr.push_back(m_page * 128 + m_col);
      exp_data.push_back(b);
      m_pend = 0;
      if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          if (m_mode == 0) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end
    end else if (m_pend == 0) begin
      m_op = b;
      if (b == 'h20 || b == 'h81 || b == 'h21 || b == 'h22 || b == 'h8D || b == 'hA8 ||
          b == 'hD3 || b == 'hD5 || b == 'hD9 || b == 'hDA || b == 'hDB) m_pend = 1;
      else if (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 'h10 && b <= 'h17) m_col = (b - 'h10) * 16 + m_col % 16;
    end else if (m_pend == 1) begin
      m_pend = 0;
      if (m_op == 'h20) m_mode = (b % 4 == 3) ? 2 : b % 4;
      else if (m_op == 'h81) m_con = b;
      else if (m_op == 'h21 || m_op == 'h22) begin m_a1 = b; m_pend = 2; end
    end else begin
      m_pend = 0;
      if (m_op == 'h21) begin m_cs = m_a1 % 128; m_ce = b % 128; m_col = m_cs; end
      else begin m_ps = m_a1 % 8; m_pe = b % 8; m_page = m_ps; end
    end
  endfunction

  // Every write strobe must match the next expected write, one entry per cycle high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fb_we !== 1'b0) begin
      if (exp_addr.size() == 0) chk("unexpected_write", {31'd0, fb_we}, 32'd0);
      else begin
        chk("fb_addr", {22'd0, fb_addr}, exp_addr.pop_front());
        chk("fb_wdata", {24'd0, fb_wdata}, exp_data.pop_front());
      end
      got_addr.push_back(fb_addr);
      got_data.push_back(fb_wdata);
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, input int h);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (h) @(negedge clk);
      sck = 1'b1;
      repeat (h) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_data, input int h);
    model_byte(b, is_data);
    @(negedge clk);
    dc = is_data;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(b, 8, h);
    repeat (6) @(negedge clk);
    chk("display_on", {31'd0, display_on}, m_disp);
    chk("invert", {31'd0, invert}, m_inv);
    chk("contrast", {24'd0, contrast}, m_con);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0, 1);
  endtask

  task automatic dat(input logic [7:0] b);
    send_byte(b, 1'b1, 1);
  endtask

  function automatic logic [7:0] rand_cmd();
    logic [7:0] c;
    case ($urandom_range(0, 13))
      0: c = 8'h20;  1: c = 8'h81;  2: c = 8'h21;  3: c = 8'h22;
      4: c = 8'h8D;  5: c = 8'hDA;  6: c = 8'hAE;  7: c = 8'hAF;
      8: c = 8'hA6;  9: c = 8'hA7;
      10: c = 8'hB0 | 8'($urandom_range(0, 7));
      11: c = 8'($urandom_range(0, 15));
      12: c = 8'h10 | 8'($urandom_range(0, 7));
      default: c = 8'($urandom);
    endcase
    return c;
  endfunction

  initial begin
    int r;
    logic [7:0] b;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_fb_we", {31'd0, fb_we}, 0);
    chk("rst_fb_addr", {22'd0, fb_addr}, 0);
    chk("rst_fb_wdata", {24'd0, fb_wdata}, 0);
    chk("rst_display_on", {31'd0, display_on}, 0);
    chk("rst_invert", {31'd0, invert}, 0);
    chk("rst_contrast", {24'd0, contrast}, 32'h7F);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Page mode default: first byte at 0, pointer steps to column 1.
    got_addr.delete(); got_data.delete();
    dat(8'hA5);
    dat(8'h01);
    chk("t1_nwrites", got_addr.size(), 2);
    if (got_addr.size() == 2) begin
      chk("t1_addr0", got_addr[0], 0);
      chk("t1_data0", got_data[0], 32'hA5);
      chk("t1_addr1", got_addr[1], 1);
    end

    // Horizontal mode, 2x2 window in the bottom-right corner.
    got_addr.delete();
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    for (int i = 0; i < 5; i++) dat(8'(i + 8'h40));
    chk("t2_nwrites", got_addr.size(), 5);
    if (got_addr.size() == 5) begin
      chk("t2_addr0", got_addr[0], 32'h37E);
      chk("t2_addr1", got_addr[1], 32'h37F);
      chk("t2_addr2", got_addr[2], 32'h3FE);
      chk("t2_addr3", got_addr[3], 32'h3FF);
      chk("t2_addr4", got_addr[4], 32'h37E);
    end

    // Vertical mode, full window.
    got_addr.delete();
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'h00); cmd(8'h7F);
    cmd(8'h22); cmd(8'h00); cmd(8'h07);
    for (int i = 0; i < 9; i++) dat(8'(i));
    chk("t3_nwrites", got_addr.size(), 9);
    if (got_addr.size() == 9) begin
      for (int i = 0; i < 8; i++) chk("t3_addr", got_addr[i], i * 128);
      chk("t3_addr8", got_addr[8], 1);
    end

    // Data byte aborts a pending 0x81; parser must be back in CMD afterwards.
    got_addr.delete(); got_data.delete();
    cmd(8'h81);
    dat(8'h11);
    chk("t4_contrast", {24'd0, contrast}, 32'h7F);
    chk("t4_nwrites", got_addr.size(), 1);
    if (got_addr.size() == 1) begin
      chk("t4_addr", got_addr[0], 129);
      chk("t4_data", got_data[0], 32'h11);
    end
    cmd(8'hAF);
    chk("t4_display_on", {31'd0, display_on}, 1);
    cmd(8'hA7);
    chk("t4_invert", {31'd0, invert}, 1);

    // Partial byte discarded by cs_n high.
    got_addr.delete(); got_data.delete();
    @(negedge clk); dc = 1'b1; cs_n = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'hFF, 4, 1);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    dat(8'h3C);
    chk("t5_nwrites", got_addr.size(), 1);
    if (got_data.size() == 1) chk("t5_data", got_data[0], 32'h3C);

    // Asynchronous reset while 0x21 waits for its second argument and mid-byte.
    cmd(8'h81); cmd(8'h33);
    cmd(8'h21); cmd(8'h05);
    @(negedge clk); dc = 1'b0; cs_n = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'hE0, 3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_display_on", {31'd0, display_on}, 0);
    chk("t6_async_invert", {31'd0, invert}, 0);
    chk("t6_async_contrast", {24'd0, contrast}, 32'h7F);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got_addr.delete();
    for (int i = 0; i < 7; i++) dat(8'h5A);
    chk("t6_nwrites", got_addr.size(), 7);
    if (got_addr.size() == 7) begin
      chk("t6_addr0", got_addr[0], 0);
      chk("t6_addr6", got_addr[6], 6);
    end

    // Random byte stream with random sck rate and cs_n gaps.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); cs_n = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      r = $urandom_range(0, 99);
      if (r < 45) send_byte(8'($urandom), 1'b1, $urandom_range(1, 3));
      else begin
        b = (r < 85) ? rand_cmd() : 8'($urandom);
        send_byte(b, 1'b0, $urandom_range(1, 3));
      end
    end
    repeat (8) @(negedge clk);
    chk("pending_writes", exp_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_sink.md
# ssd1306_spi_sink

SPI-slave command/data sink that consumes the serial stream produced by the ATmega SPI master (plus the GPIO-driven `cs_n`/`dc` lines) and models the SSD1306 OLED controller's write path. It deserializes bytes and decodes the SSD1306 command subset used by the game firmware. Data bytes are written into a 128x64 monochrome framebuffer RAM that lives outside this block. The block sits directly downstream of the SPI master and upstream of the video scan-out.

## Interface
- `COLS`, 128, framebuffer columns; column pointer width 7 bits.
- `PAGES`, 8, 8-pixel pages; page pointer width 3 bits.
- `FB_ADDR_LEN`, 10, framebuffer byte-address width; address = `page*COLS + col`.
- `clk`  in  1  system clock, same domain as the SPI master.
- `rst`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock from master (mode 0, CPOL=0).
- `mosi`  in  1  serial data, MSB first.
- `cs_n`  in  1  chip select, active low.
- `dc`  in  1  0 = command byte, 1 = data byte.
- `fb_we`  out  1  one-cycle framebuffer write strobe.
- `fb_addr`  out  FB_ADDR_LEN  framebuffer byte address.
- `fb_wdata`  out  8  byte to write (bit0 = top pixel of page).
- `display_on`  out  1  set by 0xAF, cleared by 0xAE.
- `invert`  out  1  set by 0xA7, cleared by 0xA6.
- `contrast`  out  8  value from the 0x81 argument.

## Operation
- Input conditioning: `sck`, `mosi`, `cs_n`, `dc` each pass through a 2-FF synchronizer of equal depth. A rising edge is detected when synced `sck` = 1 and its delayed copy = 0.
- Shifter: on each rising edge with synced `cs_n` = 0, shift `{sr[6:0], mosi_s}` and increment a 3-bit bit counter.
  - On the 8th bit, the byte is complete. Latch the byte and `dc_s` and raise internal `byte_vld` for 1 cycle. The counter wraps to 0.
- `cs_n` high clears the bit counter and discards any partial byte. Parser state and pointers are preserved across `cs_n` toggles.
- Parser FSM states: CMD, ARG1, ARG2.
  - CMD, 1-arg commands: 0x20 (addressing mode, arg[1:0]; value 3 is treated as 2), 0x81 (contrast). These go to ARG1 with the opcode held.
  - CMD, 2-arg commands: 0x21 (col start/end, arg[6:0]), 0x22 (page start/end, arg[2:0]). These go to ARG1, then ARG2.
  - CMD, consumed-and-ignored 1-arg commands: 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB.
  - CMD, 0-arg commands:
    - 0xAE/0xAF and 0xA6/0xA7 as listed in Interface.
    - 0xB0–0xB7 set the page pointer to [2:0].
    - 0x00–0x0F set col[3:0]; 0x10–0x17 set col[6:4].
    - All other opcodes are ignored.
  - 0x21 completion: col_start = ARG1, col_end = ARG2, col pointer = col_start. 0x22 completion behaves the same way for pages.
  - A data byte (`dc`=1) received in ARG1/ARG2 aborts the pending command (no field updated) and is processed as data; the FSM returns to CMD.
- Data byte: write `fb_addr = {page, col}`, `fb_wdata = byte`, then advance the pointers by mode:
  - Horizontal (0): col++. At col == col_end, col = col_start and page advances (page == page_end → page_start, else +1).
  - Vertical (1): page++. At page == page_end, page = page_start and col advances (col == col_end → col_start, else +1).
  - Page (2): col++. At col == col_end, col = col_start; page is unchanged.
- Pointers are only compared for equality against the end values. If start > end, the pointer counts up to the field maximum, wraps to 0 by field width, and continues until it equals end.
- Reset values: fb_we 0, fb_addr 0, fb_wdata 0, display_on 0, invert 0, contrast 0x7F, mode 2, col/page 0, col_start 0, col_end 127, page_start 0, page_end 7, FSM CMD, bit counter 0.

## Timing
- Let edge k be the first clk edge that samples the 8th `sck` high. Then:
  - `byte_vld` is registered at k+2.
  - `fb_we` is high for exactly one cycle following edge k+3, with `fb_addr`/`fb_wdata` valid in that same cycle.
  - Register/parser updates for a command byte are visible after edge k+3.
- Pointer advance occurs at the same edge that asserts `fb_we`.
- Minimum supported `sck`: high ≥ 1 clk and low ≥ 1 clk (master divider 0, sck = clk/2). Byte interval is ≥ 16 clk, so the parser never sees overlapping bytes.
- `mosi` and `dc` must be stable at the `sck` rising edge. `dc` must be stable from before the first bit until the 8th edge.
- Reset assertion mid-byte or mid-command returns every register to its reset value immediately (asynchronous). The first byte after reset release starts at bit 0.

## Test plan
- Reset, then data 0xA5 (dc=1) → one `fb_we` pulse, fb_addr 0, fb_wdata 0xA5, col becomes 1, page stays 0 (page mode).
- Cmds 0x20,0x00; 0x21,0x7E,0x7F; 0x22,0x06,0x07, then 5 data bytes → addrs 0x37E, 0x37F, 0x3FE, 0x3FF, 0x37E.
- Vertical mode (0x20,0x01), full range, 9 data bytes → addrs 0,128,…,896, then 1.
- 0x81 sent, then data 0x11 before the arg → contrast stays 0x7F, 0x11 written at current address, FSM back in CMD; following 0xAF sets display_on = 1.
- 4 bits clocked, `cs_n` pulsed high, then full byte 0x3C with dc=1 → single write of 0x3C; no write from the partial byte.
- Reset asserted during ARG2 of 0x21, then data byte → written at addr 0 with col_end 127.
